// File: rtl/thor2022_regfile_source_pkg.sv
// Shared types and sizes for the register-source (rename) tracker and its helpers.
package thor2022_regfile_source_pkg;

    localparam int NREGS       = 64;
    localparam int REB_ENTRIES = 8;
    localparam int IDW         = 3;
    localparam int RW          = 6;
    localparam int CNTW        = IDW + 1;

    typedef logic [IDW-1:0]  rebid_t;
    typedef logic [RW-1:0]   regno_t;
    typedef logic [CNTW-1:0] cnt_t;

    // The all-ones id never names a real entry, so it doubles as "no producer".
    localparam rebid_t REB_NONE = 3'd7;
    localparam cnt_t   CNT_INIT = cnt_t'(REB_ENTRIES);
    localparam cnt_t   CNT_LAST = cnt_t'(1);

    typedef enum logic {IDLE, RECOVER} src_state_e;

endpackage

// File: rtl/thor2022_regfile_source_livetarget_gen.sv
// Derives livetarget and per-entry latestID from entry valid/target and the source map.
module thor2022_livetarget_gen
    import thor2022_regfile_source_pkg::*;
(
    input  logic [REB_ENTRIES-1:0]            ent_v,
    input  regno_t [REB_ENTRIES-1:0]          ent_tgt,
    input  rebid_t [NREGS-1:0]                src,
    output logic [NREGS-1:0]                  livetarget,
    output logic [REB_ENTRIES-1:0][NREGS-1:0] latestID
);

    always_comb begin
        livetarget = '0;
        latestID   = '0;
        for (int e = 0; e < REB_ENTRIES; e++) begin
            if (ent_v[e]) begin
                livetarget[ent_tgt[e]] = 1'b1;
                // Only the entry the map points at is the newest writer of its register.
                if (src[ent_tgt[e]] == rebid_t'(e))
                    latestID[e][ent_tgt[e]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thor2022_regfile_source.sv
// Register-source tracker: maps each architectural register to its pending producer
// and rebuilds that map with an oldest-to-youngest walk after a branch miss.
module thor2022_regfile_source
    import thor2022_regfile_source_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dec0_v,
    input  logic                              dec1_v,
    input  logic [IDW-1:0]                    dec0_id,
    input  logic [IDW-1:0]                    dec1_id,
    input  logic                              dec0_rfwr,
    input  logic                              dec1_rfwr,
    input  logic [RW-1:0]                     dec0_Rt,
    input  logic [RW-1:0]                     dec1_Rt,
    input  logic                              commit0_wr,
    input  logic                              commit1_wr,
    input  logic [IDW-1:0]                    commit0_id,
    input  logic [IDW-1:0]                    commit1_id,
    input  logic [RW-1:0]                     commit0_tgt,
    input  logic [RW-1:0]                     commit1_tgt,
    input  logic                              branchmiss,
    input  logic [REB_ENTRIES-1:0]            miss_mask,
    input  logic [IDW-1:0]                    head,
    output logic [NREGS-1:0][RW-1:0]          regfile_src,
    output logic [NREGS-1:0]                  livetarget,
    output logic [REB_ENTRIES-1:0][NREGS-1:0] latestID,
    output logic                              stall
);

    logic [REB_ENTRIES-1:0] ent_v, ent_v_nxt;
    regno_t [REB_ENTRIES-1:0] ent_tgt, ent_tgt_nxt;
    rebid_t [NREGS-1:0] src, src_nxt;
    src_state_e state, state_nxt;
    rebid_t wp, wp_nxt;
    cnt_t cnt, cnt_nxt;

    regno_t walk_tgt;
    logic   walk_blocked, walk_wr, dec_ok, dec0_alloc, dec1_alloc;

    assign walk_tgt     = ent_tgt[wp];
    // A commit retiring the walked entry, or its register, overrides the rebuilt mapping.
    assign walk_blocked = (commit0_wr && (commit0_id == wp || commit0_tgt == walk_tgt)) ||
                          (commit1_wr && (commit1_id == wp || commit1_tgt == walk_tgt));
    assign walk_wr      = (state == RECOVER) && !branchmiss && ent_v[wp] && !walk_blocked;
    assign dec_ok       = (state == IDLE) && !branchmiss;
    assign dec0_alloc   = dec_ok && dec0_v && dec0_rfwr && (dec0_Rt != '0);
    assign dec1_alloc   = dec_ok && dec0_v && dec1_v && dec1_rfwr && (dec1_Rt != '0);

    always_comb begin
        ent_v_nxt   = ent_v;
        ent_tgt_nxt = ent_tgt;
        src_nxt     = src;
        state_nxt   = state;
        wp_nxt      = wp;
        cnt_nxt     = cnt;

        if (walk_wr)
            src_nxt[walk_tgt] = wp;

        if (commit0_wr) begin
            ent_v_nxt[commit0_id] = 1'b0;
            if (src[commit0_tgt] == commit0_id)
                src_nxt[commit0_tgt] = REB_NONE;
        end
        if (commit1_wr) begin
            ent_v_nxt[commit1_id] = 1'b0;
            if (src[commit1_tgt] == commit1_id)
                src_nxt[commit1_tgt] = REB_NONE;
        end

        if (branchmiss) begin
            ent_v_nxt = ent_v_nxt & ~miss_mask;
            for (int r = 0; r < NREGS; r++) begin
                if (src[r] != REB_NONE && miss_mask[src[r]])
                    src_nxt[r] = REB_NONE;
            end
            state_nxt = RECOVER;
            wp_nxt    = head;
            cnt_nxt   = CNT_INIT;
        end else if (state == RECOVER) begin
            wp_nxt  = wp + 1'b1;
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_LAST)
                state_nxt = IDLE;
        end

        // Slot 1 is younger, so it is applied last and wins a shared target.
        if (dec0_alloc) begin
            ent_v_nxt[dec0_id]   = 1'b1;
            ent_tgt_nxt[dec0_id] = dec0_Rt;
            src_nxt[dec0_Rt]     = dec0_id;
        end
        if (dec1_alloc) begin
            ent_v_nxt[dec1_id]   = 1'b1;
            ent_tgt_nxt[dec1_id] = dec1_Rt;
            src_nxt[dec1_Rt]     = dec1_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_v <= '0;
            src   <= {NREGS{REB_NONE}};
            state <= IDLE;
            wp    <= '0;
            cnt   <= '0;
        end else begin
            ent_v <= ent_v_nxt;
            src   <= src_nxt;
            state <= state_nxt;
            wp    <= wp_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Targets are only observed through ent_v, so they need no reset.
    always_ff @(posedge clk) begin
        ent_tgt <= ent_tgt_nxt;
    end

    always_comb begin
        regfile_src = '0;
        for (int r = 0; r < NREGS; r++)
            regfile_src[r] = regno_t'(src[r]);
    end

    assign stall = (state == RECOVER);

    thor2022_livetarget_gen u_livetarget_gen (
        .ent_v      (ent_v),
        .ent_tgt    (ent_tgt),
        .src        (src),
        .livetarget (livetarget),
        .latestID   (latestID)
    );

endmodule

// File: tb/tb_thor2022_regfile_source.sv
// Scoreboard bench: a rule-level model predicts every cycle's outputs; a monitor compares.
module tb_thor2022_regfile_source;
    import thor2022_regfile_source_pkg::*;

    logic clk = 1'b0;
    logic rst, dec0_v, dec1_v, dec0_rfwr, dec1_rfwr, commit0_wr, commit1_wr, branchmiss;
    logic [IDW-1:0] dec0_id, dec1_id, commit0_id, commit1_id, head;
    logic [RW-1:0] dec0_Rt, dec1_Rt, commit0_tgt, commit1_tgt;
    logic [REB_ENTRIES-1:0] miss_mask;
    logic [NREGS-1:0][RW-1:0] regfile_src;
    logic [NREGS-1:0] livetarget;
    logic [REB_ENTRIES-1:0][NREGS-1:0] latestID;
    logic stall;

    thor2022_regfile_source dut (
        .clk(clk), .rst(rst),
        .dec0_v(dec0_v), .dec1_v(dec1_v), .dec0_id(dec0_id), .dec1_id(dec1_id),
        .dec0_rfwr(dec0_rfwr), .dec1_rfwr(dec1_rfwr), .dec0_Rt(dec0_Rt), .dec1_Rt(dec1_Rt),
        .commit0_wr(commit0_wr), .commit1_wr(commit1_wr), .commit0_id(commit0_id),
        .commit1_id(commit1_id), .commit0_tgt(commit0_tgt), .commit1_tgt(commit1_tgt),
        .branchmiss(branchmiss), .miss_mask(miss_mask), .head(head),
        .regfile_src(regfile_src), .livetarget(livetarget), .latestID(latestID), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREGS-1:0][RW-1:0]          src;
        logic [NREGS-1:0]                  lt;
        logic [REB_ENTRIES-1:0][NREGS-1:0] lid;
        logic                              stall;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;
    int checks = 0;
    int errors = 0;

    // Reference state: who owns each register, which entries are live, recovery progress.
    int m_src[NREGS];
    bit m_v[REB_ENTRIES];
    int m_tgt[REB_ENTRIES];
    bit m_rec;
    int m_wp, m_left;
    int fr[$];
    int vl[$];
    int a;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [RW-1:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, 5));
    endfunction

    task automatic model_step();
        int ns[NREGS];
        bit nv[REB_ENTRIES];
        int nt[REB_ENTRIES];
        int t;
        bit blocked;
        exp_t x;
        if (rst) begin
            foreach (m_v[e]) m_v[e] = 1'b0;
            foreach (m_src[r]) m_src[r] = 7;
            m_rec = 1'b0;
            m_wp = 0;
            m_left = 0;
        end else begin
            ns = m_src; nv = m_v; nt = m_tgt;
            if (m_rec && !branchmiss && m_v[m_wp]) begin
                t = m_tgt[m_wp];
                blocked = (commit0_wr && (int'(commit0_id) == m_wp || int'(commit0_tgt) == t)) ||
                          (commit1_wr && (int'(commit1_id) == m_wp || int'(commit1_tgt) == t));
                if (!blocked) ns[t] = m_wp;
            end
            if (commit0_wr) begin
                nv[commit0_id] = 1'b0;
                if (m_src[commit0_tgt] == int'(commit0_id)) ns[commit0_tgt] = 7;
            end
            if (commit1_wr) begin
                nv[commit1_id] = 1'b0;
                if (m_src[commit1_tgt] == int'(commit1_id)) ns[commit1_tgt] = 7;
            end
            if (branchmiss) begin
                for (int e = 0; e < REB_ENTRIES; e++) if (miss_mask[e]) nv[e] = 1'b0;
                for (int r = 0; r < NREGS; r++)
                    if (m_src[r] != 7 && miss_mask[m_src[r]]) ns[r] = 7;
            end else if (!m_rec) begin
                if (dec0_v && dec0_rfwr && dec0_Rt != 0) begin
                    nv[dec0_id] = 1'b1; nt[dec0_id] = dec0_Rt; ns[dec0_Rt] = dec0_id;
                end
                if (dec0_v && dec1_v && dec1_rfwr && dec1_Rt != 0) begin
                    nv[dec1_id] = 1'b1; nt[dec1_id] = dec1_Rt; ns[dec1_Rt] = dec1_id;
                end
            end
            if (branchmiss) begin
                m_rec = 1'b1; m_wp = int'(head); m_left = REB_ENTRIES;
            end else if (m_rec) begin
                m_wp = (m_wp + 1) % REB_ENTRIES;
                m_left--;
                if (m_left == 0) m_rec = 1'b0;
            end
            m_src = ns; m_v = nv; m_tgt = nt;
        end
        x.lt = '0;
        x.lid = '0;
        for (int r = 0; r < NREGS; r++) x.src[r] = 6'(m_src[r]);
        for (int e = 0; e < REB_ENTRIES; e++) begin
            if (m_v[e]) begin
                x.lt[m_tgt[e]] = 1'b1;
                if (m_src[m_tgt[e]] == e) x.lid[e] = 64'd1 << m_tgt[e];
            end
        end
        x.stall = m_rec;
        exp_q.push_back(x);
    endtask

    task automatic clr();
        rst = 0; dec0_v = 0; dec1_v = 0; dec0_rfwr = 0; dec1_rfwr = 0;
        dec0_id = 0; dec1_id = 0; dec0_Rt = 0; dec1_Rt = 0;
        commit0_wr = 0; commit1_wr = 0; commit0_id = 0; commit1_id = 0;
        commit0_tgt = 0; commit1_tgt = 0; branchmiss = 0; miss_mask = 0; head = 0;
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic expect_walk(string name);
        for (int i = 0; i < REB_ENTRIES; i++) begin
            chk(name, 512'(stall), 512'(1));
            clr();
            step();
        end
        chk(name, 512'(stall), 512'(0));
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            chk("regfile_src", 512'(regfile_src), 512'(mx.src));
            chk("livetarget", 512'(livetarget), 512'(mx.lt));
            chk("latestID", 512'(latestID), 512'(mx.lid));
            chk("stall", 512'(stall), 512'(mx.stall));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        foreach (m_tgt[e]) m_tgt[e] = 0;
        clr();
        @(negedge clk);
        rst = 1; step(); step();

        clr(); dec0_v = 1; dec0_id = 2; dec0_rfwr = 1; dec0_Rt = 5; step();
        chk("src5", 512'(regfile_src[5]), 512'(2));
        chk("lt5", 512'(livetarget[5]), 512'(1));
        chk("lid2", 512'(latestID[2]), 512'(64'd1 << 5));

        clr(); dec0_v = 1; dec0_id = 1; dec0_rfwr = 1; dec0_Rt = 9;
        dec1_v = 1; dec1_id = 3; dec1_rfwr = 1; dec1_Rt = 9; step();
        chk("src9", 512'(regfile_src[9]), 512'(3));
        chk("lid1", 512'(latestID[1]), 512'(0));
        chk("lid3", 512'(latestID[3]), 512'(64'd1 << 9));

        clr(); dec0_v = 1; dec0_id = 4; dec0_rfwr = 1; dec0_Rt = 7; step();
        clr(); commit0_wr = 1; commit0_id = 4; commit0_tgt = 7; step();
        chk("src7_cleared", 512'(regfile_src[7]), 512'(7));
        chk("lt7", 512'(livetarget[7]), 512'(0));
        clr(); dec0_v = 1; dec0_id = 4; dec0_rfwr = 1; dec0_Rt = 7; step();
        clr(); commit0_wr = 1; commit0_id = 4; commit0_tgt = 7;
        dec0_v = 1; dec0_id = 0; dec0_rfwr = 1; dec0_Rt = 7; step();
        chk("src7_decode_wins", 512'(regfile_src[7]), 512'(0));

        clr(); commit0_wr = 1; commit0_id = 1; commit0_tgt = 9;
        commit1_wr = 1; commit1_id = 3; commit1_tgt = 9; step();
        clr(); commit0_wr = 1; commit0_id = 2; commit0_tgt = 5;
        commit1_wr = 1; commit1_id = 0; commit1_tgt = 7; step();
        clr(); dec0_v = 1; dec0_id = 1; dec0_rfwr = 1; dec0_Rt = 6;
        dec1_v = 1; dec1_id = 5; dec1_rfwr = 1; dec1_Rt = 6; step();
        clr(); branchmiss = 1; miss_mask = 8'h20; head = 1; step();
        expect_walk("walk1_stall");
        chk("src6_walk", 512'(regfile_src[6]), 512'(1));
        chk("lid5_squashed", 512'(latestID[5]), 512'(0));

        clr(); dec0_v = 1; dec0_id = 2; dec0_rfwr = 1; dec0_Rt = 10;
        dec1_v = 1; dec1_id = 3; dec1_rfwr = 1; dec1_Rt = 10; step();
        clr(); branchmiss = 1; miss_mask = 8'h08; head = 2; step();
        for (int i = 0; i < 3; i++) begin clr(); step(); end
        clr(); branchmiss = 1; miss_mask = 8'h04; head = 1; step();
        expect_walk("walk2_stall");
        chk("src10_restart", 512'(regfile_src[10]), 512'(7));
        chk("src6_restart", 512'(regfile_src[6]), 512'(1));

        clr(); dec0_v = 1; dec0_id = 4; dec0_rfwr = 1; dec0_Rt = 0; step();
        chk("src0", 512'(regfile_src[0]), 512'(7));
        chk("lt0", 512'(livetarget[0]), 512'(0));
        clr(); branchmiss = 1; step();
        clr(); step(); step();
        clr(); rst = 1; step();
        chk("rst_stall", 512'(stall), 512'(0));
        chk("rst_src", 512'(regfile_src), 512'({NREGS{6'd7}}));
        clr(); step();

        for (int c = 0; c < 3000; c++) begin
            clr();
            fr.delete(); vl.delete();
            for (int e = 0; e < REB_ENTRIES - 1; e++)
                if (m_v[e]) vl.push_back(e); else fr.push_back(e);
            if (fr.size() > 0 && $urandom_range(0, 2) != 0) begin
                a = $urandom_range(0, fr.size() - 1);
                dec0_v = 1; dec0_id = 3'(fr[a]); dec0_rfwr = ($urandom_range(0, 4) != 0);
                dec0_Rt = rnd_reg(); fr.delete(a);
                if (fr.size() > 0 && $urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, fr.size() - 1);
                    dec1_v = 1; dec1_id = 3'(fr[a]); dec1_rfwr = ($urandom_range(0, 4) != 0);
                    dec1_Rt = rnd_reg();
                end
            end
            if (vl.size() > 0 && $urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, vl.size() - 1);
                commit0_wr = 1; commit0_id = 3'(vl[a]); commit0_tgt = 6'(m_tgt[vl[a]]);
                vl.delete(a);
                if (vl.size() > 0 && $urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, vl.size() - 1);
                    commit1_wr = 1; commit1_id = 3'(vl[a]); commit1_tgt = 6'(m_tgt[vl[a]]);
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                branchmiss = 1; miss_mask = {1'b0, 7'($urandom)}; head = 3'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 799) == 0) rst = 1;
            step();
        end

        clr();
        @(posedge clk);
        #2;
        chk("drain", 512'(exp_q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
